// File: rtl/mem_ctrl_if.sv
// Bundles the MEM-stage, IF-stage and RAM-bus signals of mem_ctrl.
// io_buffer_full exists only when MEM_CTRL_IO_STALL_EN is defined.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              read_mem;
   logic              write_mem;
   logic [ADDR_W-1:0] mem_addr_to_read;
   logic [31:0]       mem_data_to_write;
   logic [2:0]        data_len;
   logic              mem_load_done;
   logic [1:0]        mem_ctrl_busy_state;
   logic [31:0]       mem_ctrl_read_in;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_data;

   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;
`ifdef MEM_CTRL_IO_STALL_EN
   logic              io_buffer_full;
`endif

   // The controller side: requests come in, RAM bus and done pulses go out.
   modport slave (
`ifdef MEM_CTRL_IO_STALL_EN
      input  io_buffer_full,
`endif
      input  read_mem, write_mem, mem_addr_to_read, mem_data_to_write, data_len,
      input  if_req, if_addr, ram_din,
      output mem_load_done, mem_ctrl_busy_state, mem_ctrl_read_in,
      output if_done, if_data, ram_dout, ram_a, ram_wr
   );

   modport master (
`ifdef MEM_CTRL_IO_STALL_EN
      output io_buffer_full,
`endif
      output read_mem, write_mem, mem_addr_to_read, mem_data_to_write, data_len,
      output if_req, if_addr, ram_din,
      input  mem_load_done, mem_ctrl_busy_state, mem_ctrl_read_in,
      input  if_done, if_data, ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises MEM load/store and IF fetch requests into byte accesses on the
// 8-bit RAM bus. Optional IO write backpressure: MEM_CTRL_IO_STALL_EN.
module mem_ctrl #(
   parameter int ADDR_W = 32
`ifdef MEM_CTRL_IO_STALL_EN
   , parameter logic [1:0] IO_BASE_HI = 2'b11
`endif
) (
   input logic        clk_in,
   input logic        rst_in,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      DREAD,
      DWRITE,
      IFREAD,
      DDONE,
      IFDONE
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [ADDR_W-1:0] ram_a_r;
   logic [2:0]        len_r;
   logic [2:0]        cnt;
   logic [31:0]       wbuf;
   logic [31:0]       rbuf;
   logic              len_ok;
   logic              stall;
   logic              addr_step;

   assign len_ok    = (bus.data_len == 3'd1) || (bus.data_len == 3'd2) ||
                      (bus.data_len == 3'd4);
   assign addr_step = (cnt + 3'd1) < len_r;

   // A write byte is held back while the IO region reports a full buffer.
`ifdef MEM_CTRL_IO_STALL_EN
   assign stall = (state == DWRITE) && (ram_a_r[17:16] == IO_BASE_HI) &&
                  bus.io_buffer_full;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // In reads, cnt runs one past the last address so the final byte's data
   // (arriving a cycle late) is captured before the done state.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.write_mem) begin
               next_state = len_ok ? DWRITE : IDLE;
            end else if (bus.read_mem) begin
               next_state = len_ok ? DREAD : IDLE;
            end else if (bus.if_req) begin
               next_state = IFREAD;
            end
         end
         DREAD: begin
            if (cnt == len_r) next_state = DDONE;
         end
         IFREAD: begin
            if (cnt == len_r) next_state = IFDONE;
         end
         DWRITE: begin
            if (!stall && (cnt == len_r - 3'd1)) next_state = DDONE;
         end
         DDONE:   next_state = IDLE;
         IFDONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ram_a_r <= '0;
         len_r   <= '0;
         cnt     <= '0;
         wbuf    <= '0;
         rbuf    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((next_state == DREAD) || (next_state == DWRITE)) begin
                  ram_a_r <= bus.mem_addr_to_read;
                  len_r   <= bus.data_len;
                  wbuf    <= bus.mem_data_to_write;
                  cnt     <= '0;
                  rbuf    <= '0;
               end else if (next_state == IFREAD) begin
                  ram_a_r <= bus.if_addr;
                  len_r   <= 3'd4;
                  cnt     <= '0;
                  rbuf    <= '0;
               end
            end
            DREAD, IFREAD: begin
               cnt <= cnt + 3'd1;
               if (addr_step) ram_a_r <= ram_a_r + ADDR_W'(1);
               case (cnt)
                  3'd1:    rbuf[7:0]   <= bus.ram_din;
                  3'd2:    rbuf[15:8]  <= bus.ram_din;
                  3'd3:    rbuf[23:16] <= bus.ram_din;
                  3'd4:    rbuf[31:24] <= bus.ram_din;
                  default: ;
               endcase
            end
            DWRITE: begin
               if (!stall) begin
                  cnt  <= cnt + 3'd1;
                  wbuf <= {8'h00, wbuf[31:8]};
                  if (addr_step) ram_a_r <= ram_a_r + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // rbuf is cleared on every acceptance, so a store's done presents zero.
   always_comb begin
      bus.ram_a               = ram_a_r;
      bus.ram_wr              = 1'b0;
      bus.ram_dout            = 8'h00;
      bus.mem_load_done       = 1'b0;
      bus.mem_ctrl_read_in    = 32'h0;
      bus.if_done             = 1'b0;
      bus.if_data             = 32'h0;
      bus.mem_ctrl_busy_state = 2'b00;
      case (state)
         DREAD: begin
            bus.mem_ctrl_busy_state = 2'b10;
         end
         DWRITE: begin
            bus.mem_ctrl_busy_state = 2'b10;
            bus.ram_wr              = !stall;
            bus.ram_dout            = wbuf[7:0];
         end
         IFREAD: begin
            bus.mem_ctrl_busy_state = 2'b11;
         end
         DDONE: begin
            bus.mem_ctrl_busy_state = 2'b10;
            bus.mem_load_done       = 1'b1;
            bus.mem_ctrl_read_in    = rbuf;
         end
         IFDONE: begin
            bus.mem_ctrl_busy_state = 2'b11;
            bus.if_done             = 1'b1;
            bus.if_data             = rbuf;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller and responder for the MEM stage's load/store requests and the IF stage's instruction fetches.
- Serialises each request into byte accesses on the 8-bit synchronous RAM/IO bus.
- Returns a one-cycle done pulse with the little-endian assembled result.
- Sits between the MEM/IF stages and the external RAM port at the top level.

Parameters:
ADDR_W, 32, width of all address buses
IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region (used only with the optional feature)

Ports:
clk_in  input  1  system clock, all state updates on posedge
rst_in  input  1  asynchronous, active-low reset
read_mem  input  1  MEM load request (level, held by MEM while stalled)
write_mem  input  1  MEM store request (level)
mem_addr_to_read  input  32  byte address of load/store
mem_data_to_write  input  32  store data, byte0 = [7:0]
data_len  input  3  bytes to transfer: 1, 2 or 4
mem_load_done  output  1  one-cycle pulse; MEM transaction complete
mem_ctrl_busy_state  output  2  [1]=data side cannot accept, [0]=IF transaction in flight
mem_ctrl_read_in  output  32  assembled load data, valid while mem_load_done=1
if_req  input  1  instruction fetch request (level)
if_addr  input  32  fetch address
if_done  output  1  one-cycle pulse; fetch complete
if_data  output  32  fetched word, valid while if_done=1
ram_din  input  8  RAM read byte, valid the cycle after its address
ram_dout  output  8  RAM write byte
ram_a  output  32  RAM byte address
ram_wr  output  1  1=write, 0=read
io_buffer_full  input  1  IO write backpressure (present only with MEM_CTRL_IO_STALL_EN)

Behaviour:
- Reset (rst_in=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: ram_wr=0, ram_a=0, ram_dout=0, both done pulses 0, busy=2'b00, read_in=0, if_data=0.
  - A reset mid-transaction aborts it silently; no done pulse is issued.
- States are IDLE, DREAD, DWRITE, IFREAD, DDONE and IFDONE.
- Acceptance:
  - Requests are sampled only in IDLE. Priority is write_mem > read_mem > if_req.
  - Address, data and length are latched at acceptance. Later changes to the inputs are ignored.
  - data_len not in {1,2,4} is not accepted; the controller stays IDLE.
  - There is no preemption. An IF request arriving during a data transaction waits, and vice versa.
- Busy flags:
  - busy[1] is 1 in every state except IDLE.
  - busy[0] is 1 in IFREAD and IFDONE.
  - busy[1] is the signal MEM uses to withhold its request.
- Read timing (n = len, accept edge = cycle 0):
  - Byte i address (base+i) is driven in cycle i+1, with ram_wr=0.
  - ram_din is captured at the end of cycle i+2 into bits [8i+7:8i].
  - Unused upper bytes are 0.
  - After the last address, ram_a holds its value and ram_wr=0.
  - DDONE in cycle n+2: mem_load_done=1 and mem_ctrl_read_in is valid.
  - LW total is 6 cycles from the accept edge to the done cycle, inclusive.
- Write timing:
  - Byte i is driven in cycle i+1, with ram_wr=1, ram_a=base+i, ram_dout=data[8i+7:8i].
  - DDONE in cycle n+1: mem_load_done=1, mem_ctrl_read_in=0, ram_wr=0.
- Fetch: same as a read with n=4, using IFREAD then IFDONE, if_done and if_data.
- Done states:
  - DDONE and IFDONE last exactly one cycle, then return to IDLE.
  - No request is accepted in a done cycle.
  - A request held through the done cycle is accepted on the next IDLE cycle. MEM and IF must therefore drop their request in the done cycle.
- Address arithmetic is modulo 2^32; base+i wraps at 0xFFFFFFFF.
- Outside active phases, ram_wr=0 always. ram_wr is never 1 during IDLE or any done state.

Optional Feature:
MEM_CTRL_IO_STALL_EN
- Defined:
  - The io_buffer_full port exists.
  - In DWRITE, if the current byte address has addr[17:16]==IO_BASE_HI and io_buffer_full=1, that cycle drives ram_wr=0 and the byte index does not advance.
  - The write resumes the cycle after io_buffer_full falls.
  - The done pulse is delayed by the number of stall cycles.
- Undefined:
  - No io_buffer_full port.
  - Writes never stall and the timing is exactly as above.

Test Plan:
- Reset mid-LW (rst_in low in cycle 3) -> all outputs 0 immediately; no mem_load_done afterwards; busy=00.
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 -> ram_a 0x100..0x103 in cycles 1-4; done in cycle 6 with read_in=0x44332211; busy[1]=1 cycles 1-6.
- SH data 0xABCD1234 at 0x200 -> cycle 1: ram_a=0x200, ram_dout=0x34, wr=1; cycle 2: ram_a=0x201, ram_dout=0x12, wr=1; done in cycle 3.
- Simultaneous read_mem (LB at 0x5) and if_req (0x0) in IDLE -> LB served first, read_in=0x000000xx; fetch accepted the cycle after DDONE; if_done 6 cycles later; busy[0]=1 only during the fetch.
- data_len=3 with read_mem=1 -> stays IDLE, no RAM access, busy=00.
- With MEM_CTRL_IO_STALL_EN: SB to 0x30000 with io_buffer_full=1 for 3 cycles -> ram_wr=0 for those cycles, then one write of byte0; done 3 cycles later than the unstalled case.
